// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the memory stage.
//   execute_t   - EX/MEM bundle produced by the execute stage
//   memory_t    - MEM/WB bundle consumed by writeback
//   mem_state_t - memory-stage request FSM states
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] store_data;
        logic              dREN;
        logic              dWEN;
        logic              is_ll;
        logic              is_sc;
        logic              RegWr;
        logic [SEL_W-1:0]  wsel;
        logic              halt;
        logic [DATA_W-1:0] pc;
    } execute_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              RegWr;
        logic [SEL_W-1:0]  wsel;
        logic              halt;
        logic [DATA_W-1:0] pc;
    } memory_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HALTED = 2'd2
    } mem_state_t;

endpackage

// File: rtl/memory_if.sv
// memory_if: bundle between the pipeline control and the memory stage.
//   MEM modport: execute_p, ihit, dhit, stall, flush, dmemload in;
//                memory_p, mem_busy out.
interface memory_if;
    import mem_stage_pkg::*;

    execute_t          execute_p;
    logic              ihit;
    logic              dhit;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] dmemload;
    memory_t           memory_p;
    logic              mem_busy;

    modport MEM (
        input  execute_p, ihit, dhit, stall, flush, dmemload,
        output memory_p, mem_busy
    );
endinterface

// File: rtl/mem_stage_llsc_link.sv
// llsc_link: LL/SC link register and SC address check.
//   CLK, nRST    - clock, async active-low reset
//   i_addr       - effective address of the latched instruction
//   i_ll_set     - LL completing: arm the link at i_addr
//   i_sc_done    - SC completing (pass or fail): drop the link
//   i_st_done    - store completing: drop the link if it hits link_addr
//   o_link_ok    - link valid and link_addr == i_addr
module llsc_link #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] i_addr,
    input  logic              i_ll_set,
    input  logic              i_sc_done,
    input  logic              i_st_done,
    output logic              o_link_ok
);
    logic              r_link_valid;
    logic [WORD_W-1:0] r_link_addr;
    logic              w_addr_hit;

    assign w_addr_hit = (r_link_addr == i_addr);
    assign o_link_ok  = r_link_valid & w_addr_hit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else if (i_ll_set) begin
            r_link_valid <= 1'b1;
            r_link_addr  <= i_addr;
        end else if (i_sc_done || (i_st_done && w_addr_hit)) begin
            r_link_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage pipeline.
//   CLK, nRST           - clock, async active-low reset
//   execute_p           - EX/MEM input bundle from execute
//   ihit, stall, flush  - advance qualifier, EX/MEM freeze, bubble insert
//   dhit, dmemload      - dcache completion and read data
//   dmemREN/WEN/addr/store - dcache request, held from REQ entry until dhit
//   mem_busy            - memory instruction outstanding; upstream must stall
//   memory_p            - MEM/WB latch
//   halt                - sticky halt, cleared only by reset
// WORD_W / REGSEL_W must match the package struct widths.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD_W   = DATA_W,
    parameter int REGSEL_W = SEL_W,
    parameter bit LLSC_EN  = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  execute_t          execute_p,
    input  logic              ihit,
    input  logic              stall,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_busy,
    output memory_t           memory_p,
    output logic              halt
);
    mem_state_t          r_state;
    execute_t            r_exmem;
    memory_t             r_memwb;
    logic                r_halt;

    logic                w_link_ok;
    logic                w_ren;
    logic                w_wen;
    logic                w_sc_fail;
    logic                w_memop;
    logic                w_req;
    logic                w_adv;
    logic                w_done;
    logic [REGSEL_W-1:0] w_wsel;
    memory_t             w_wb;

    // dWEN wins over an illegal dREN+dWEN pair.
    assign w_wen     = r_exmem.dWEN;
    assign w_ren     = r_exmem.dREN & ~r_exmem.dWEN;
    assign w_sc_fail = r_exmem.is_sc & ~w_link_ok;
    assign w_memop   = (w_ren | w_wen) & ~w_sc_fail;
    assign w_req     = (r_state == REQ);
    assign w_done    = w_req & dhit;

    // An IDLE cycle holding a memory op is already busy so the latch is not
    // overwritten before the request is issued.
    assign mem_busy  = w_req | ((r_state == IDLE) & w_memop);
    assign w_adv     = ihit & ~stall & ~mem_busy & ~r_halt & (r_state == IDLE);

    assign dmemREN   = w_req & w_ren;
    assign dmemWEN   = w_req & w_wen;
    assign dmemaddr  = w_req ? r_exmem.alu_out    : '0;
    assign dmemstore = w_req ? r_exmem.store_data : '0;
    assign memory_p  = r_memwb;
    assign halt      = r_halt;
    assign w_wsel    = r_exmem.wsel;

    // An SC reaching MEM/WB from REQ passed the link check; from IDLE it failed.
    always_comb begin
        w_wb       = '0;
        w_wb.RegWr = r_exmem.RegWr;
        w_wb.wsel  = w_wsel;
        w_wb.halt  = r_exmem.halt;
        w_wb.pc    = r_exmem.pc;
        if (r_exmem.is_sc)
            w_wb.result = {{(DATA_W-1){1'b0}}, w_req};
        else if (w_ren)
            w_wb.result = dmemload;
        else
            w_wb.result = r_exmem.alu_out;
    end

    generate
        if (LLSC_EN) begin : g_llsc
            llsc_link #(.WORD_W(WORD_W)) u_llsc (
                .CLK       (CLK),
                .nRST      (nRST),
                .i_addr    (r_exmem.alu_out),
                .i_ll_set  (w_done & w_ren & r_exmem.is_ll),
                .i_sc_done ((w_done | w_adv) & r_exmem.is_sc),
                .i_st_done (w_done & w_wen),
                .o_link_ok (w_link_ok)
            );
        end else begin : g_no_llsc
            assign w_link_ok = 1'b1;
        end
    endgenerate

    // MEM/WB defaults to a bubble so every instruction commits exactly once.
    // A completed memory op leaves a bubble in EX/MEM for the same reason.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_exmem <= '0;
            r_memwb <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_memwb <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_memop) begin
                        r_state <= REQ;
                    end else if (w_adv) begin
                        r_memwb <= w_wb;
                        r_exmem <= flush ? '0 : execute_p;
                        if (r_exmem.halt)
                            r_state <= HALTED;
                    end
                end
                REQ: begin
                    if (dhit) begin
                        r_memwb <= w_wb;
                        r_exmem <= '0;
                        r_state <= r_exmem.halt ? HALTED : IDLE;
                    end
                end
                HALTED: r_halt <= 1'b1;
                default: r_state <= IDLE;
            endcase
        end
    end

    a_rw_exclusive: assert property (@(posedge CLK) disable iff (!nRST)
        !(r_exmem.dREN && r_exmem.dWEN));

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline, directly downstream of the execute stage.
- Holds the EX/MEM latch, fed by execute_t from execute.
- Drives the dcache request, with the request held until dhit.
- Implements the LL/SC link register.
- Registers a memory_t bundle into the MEM/WB latch, which feeds writeback.

Parameters:
- WORD_W, 32, datapath/address width
- REGSEL_W, 5, register-select width
- LLSC_EN, 1, 1 = LL/SC link register present; 0 = SC always succeeds as a plain SW

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- execute_p  input  execute_t  from execute; fields used: alu_out, store_data, dREN, dWEN, is_ll, is_sc, RegWr, wsel, halt, pc
- ihit  input  1  pipeline advance qualifier
- stall  input  1  hazard-unit freeze of the EX/MEM latch
- flush  input  1  load a bubble into EX/MEM instead of execute_p
- dhit  input  1  dcache completed the current request
- dmemload  input  WORD_W  dcache read data, valid with dhit
- dmemREN  output  1  dcache read request
- dmemWEN  output  1  dcache write request
- dmemaddr  output  WORD_W  dcache address
- dmemstore  output  WORD_W  dcache write data
- mem_busy  output  1  request outstanding; the hazard unit must stall IF/ID/EX
- memory_p  output  memory_t  MEM/WB latch: result, RegWr, wsel, halt, pc
- halt  output  1  sticky processor halt

Behaviour:
- Reset (nRST low, async): EX/MEM latch, MEM/WB latch, link_valid and link_addr all clear to 0; FSM goes to IDLE. All outputs read 0.
- EX/MEM load: at an edge with ihit && !stall && !mem_busy && !halt, load execute_p, or all-zero when flush is high. Otherwise hold.
- flush while mem_busy: ignored. The hazard unit holds flush until the latch is free.
- FSM states: IDLE, REQ, HALTED.
- IDLE -> REQ when the latched instruction has dREN or dWEN set and is not a suppressed SC.
- REQ: dmemREN/dmemWEN follow the latched bits. dmemaddr = alu_out; dmemstore = store_data. mem_busy = 1.
- REQ -> IDLE on the edge where dhit = 1. At that edge, MEM/WB captures result = dmemload for loads, or the SC status for SC. EX/MEM then becomes loadable on the next qualifying edge.
- Request lines must be held stable from entering REQ until dhit; no change mid-request.
- Non-memory instruction: MEM/WB captures result = alu_out on the qualifying edge. Latency is 1 cycle EX/MEM -> MEM/WB.
- Memory instruction latency: 1 + N cycles, where N = cycles until dhit. N = 1 on a cache hit; in that case dhit arrives in the first REQ cycle.
- While busy, MEM/WB loads a bubble (RegWr = 0) every edge until completion, so writeback never re-commits.
- Read/write exclusivity: dREN and dWEN both set is illegal. dWEN takes precedence, dREN is masked, and a simulation assertion fires.
- LL: a load that also sets link_valid = 1 and link_addr = alu_out at completion.
- SC with a valid link and link_addr == alu_out: issue the write. On dhit, result = 1 and link_valid clears.
- SC that fails the link check: no dcache request, no stall. result = 0, 1-cycle latency.
- Any completed SW with address == link_addr clears link_valid. An SC completion clears it regardless.
- Halt: when a latched instruction with halt = 1 passes to MEM/WB, the FSM enters HALTED. halt goes high the cycle after and stays high until reset. No further latch loads or requests occur.
- Reset mid-request: the request drops immediately (async); the dcache controller tolerates the abort.
- Address alignment: dmemaddr is passed through unmodified. Misaligned addresses are the cache's concern.

Decomposition:
- The following belong in the structs package: execute_t (already shared); new memory_t {result, RegWr, wsel, halt, pc}; mem_state_t enum {IDLE, REQ, HALTED}.
- A new memory_if interface mirrors the execute interface. Modport MEM takes execute_p, ihit, dhit, stall, flush and dmemload as inputs, and drives memory_p and mem_busy as outputs.
- One sub-module: llsc_link (link_valid/link_addr registers plus SC pass/fail compare), instantiated only when LLSC_EN = 1.

Test Plan:
- ALU op: alu_out = 0x0000_0042, RegWr = 1, wsel = 5 -> memory_p.result = 0x42 one edge later; dmemREN and dmemWEN stay 0; mem_busy stays 0.
- LW at 0x100 with dhit delayed 3 cycles, dmemload = 0xDEAD_BEEF:
  - dmemREN and dmemaddr = 0x100 stable for 3 cycles; mem_busy = 1 throughout.
  - MEM/WB holds bubbles, then result = 0xDEADBEEF with RegWr = 1.
- SW with store_data = 0x1234 at 0x200, plus flush asserted during REQ -> dmemWEN is held until dhit; the flush has no effect until mem_busy drops.
- LL 0x300 then SC 0x300 -> SC writes and result = 1. Repeat with an intervening SW to 0x300 -> the SC issues no request and result = 0.
- Halt instruction -> halt = 1 two edges after the EX/MEM load. Later execute_p changes are ignored. halt stays high until nRST falls.
- nRST low during a pending LW -> dmemREN = 0 and memory_p = 0 with no clock edge. The FSM is IDLE after release.
